// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC generation, single-outstanding program memory reads
// and a small prefetch FIFO that feeds the pipeline's fetch input.
module instruction_fetch_unit #(
    parameter int unsigned          ADDR_BITS  = 8,
    parameter int unsigned          INSTR_BITS = 16,
    parameter int unsigned          FIFO_DEPTH = 4,
    parameter logic [ADDR_BITS-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [ADDR_BITS-1:0]  redirect_pc,
    output logic                  mem_read_valid,
    output logic [ADDR_BITS-1:0]  mem_read_address,
    input  logic                  mem_read_ready,
    input  logic [INSTR_BITS-1:0] mem_read_data,
    output logic [INSTR_BITS-1:0] fetched_instruction,
    output logic                  fetch_valid,
    output logic [ADDR_BITS-1:0]  fetch_pc,
    output logic                  halted
);
    localparam int unsigned         PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int unsigned         CNT_BITS = PTR_BITS + 1;
    localparam logic [CNT_BITS-1:0] DEPTH    = CNT_BITS'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_SPACE, HALTED, DRAIN} state_t;

    state_t                state;
    logic [ADDR_BITS-1:0]  pc;
    logic [INSTR_BITS-1:0] instr_mem [FIFO_DEPTH];
    logic [ADDR_BITS-1:0]  pc_mem    [FIFO_DEPTH];
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [CNT_BITS-1:0]   count;

    logic push;
    logic pop;
    logic is_ret;
    logic room_now;
    logic room_after_push;

    // Only REQ pushes; the word accepted while draining belongs to the flushed path.
    assign push            = mem_read_valid && mem_read_ready && (state == REQ) && !flush;
    assign fetch_valid     = (count != '0);
    assign pop             = fetch_valid && enable && !stall && !flush;
    assign is_ret          = (mem_read_data[INSTR_BITS-1 -: 4] == 4'hF);
    assign room_now        = count < DEPTH;
    assign room_after_push = (count + 1'b1) < DEPTH;

    assign fetched_instruction = fetch_valid ? instr_mem[rd_ptr] : '0;
    assign fetch_pc            = fetch_valid ? pc_mem[rd_ptr] : '0;

    // NOTE: storage is deliberately not reset; fetch_valid gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= mem_read_data;
            pc_mem[wr_ptr]    <= mem_read_address;
        end
    end

    // NOTE: all state uses <= so every branch below reads pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            pc               <= RESET_PC;
            mem_read_valid   <= 1'b0;
            mem_read_address <= RESET_PC;
            halted           <= 1'b0;
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            halted <= 1'b0;
            pc     <= redirect_pc;
            if (mem_read_valid && !mem_read_ready) begin
                state <= DRAIN;
            end else if (enable) begin
                state            <= REQ;
                mem_read_valid   <= 1'b1;
                mem_read_address <= redirect_pc;
            end else begin
                state          <= WAIT_SPACE;
                mem_read_valid <= 1'b0;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_BITS'(push) - CNT_BITS'(pop);

            case (state)
                IDLE: begin
                    if (enable) begin
                        state            <= REQ;
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= pc;
                    end
                end
                REQ: begin
                    if (mem_read_ready) begin
                        pc <= pc + 1'b1;
                        if (is_ret) begin
                            state          <= HALTED;
                            halted         <= 1'b1;
                            mem_read_valid <= 1'b0;
                        end else if (enable && room_after_push) begin
                            mem_read_address <= pc + 1'b1;
                        end else begin
                            state          <= WAIT_SPACE;
                            mem_read_valid <= 1'b0;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (enable && room_now) begin
                        state            <= REQ;
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= pc;
                    end
                end
                HALTED: begin
                    mem_read_valid <= 1'b0;
                end
                DRAIN: begin
                    if (mem_read_ready) begin
                        state            <= enable ? REQ : WAIT_SPACE;
                        mem_read_valid   <= enable;
                        mem_read_address <= pc;
                    end
                end
                default: begin
                    state          <= IDLE;
                    mem_read_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a latency-configurable program memory
// model, a scoreboard of expected {pc, instruction} deliveries and request logs.
module tb_instruction_fetch_unit;
    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } fetch_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [15:0] fetched_instruction;
    logic        fetch_valid;
    logic [7:0]  fetch_pc;
    logic        halted;

    logic        valid_fe;
    logic [7:0]  addr_fe;
    logic        ready_fe;
    logic [15:0] data_fe;
    logic [15:0] instr_fe;
    logic        fetch_valid_fe;
    logic [7:0]  fetch_pc_fe;
    logic        halted_fe;

    int          latency = 0;
    int          wait_cnt = 0;
    logic        ret_en = 1'b0;
    logic [7:0]  ret_addr = '0;

    fetch_t      exp_q[$];
    fetch_t      got_q[$];
    logic [7:0]  req_q[$];
    logic [7:0]  req_fe_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit u_dut (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data), .fetched_instruction(fetched_instruction),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .halted(halted)
    );

    instruction_fetch_unit #(.RESET_PC(8'hFE)) u_dut_fe (
        .clk(clk), .reset(reset), .enable(enable), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .mem_read_valid(valid_fe),
        .mem_read_address(addr_fe), .mem_read_ready(ready_fe),
        .mem_read_data(data_fe), .fetched_instruction(instr_fe),
        .fetch_valid(fetch_valid_fe), .fetch_pc(fetch_pc_fe), .halted(halted_fe)
    );

    // Program memory: word = addr | 0x3000, optional RET at ret_addr, ready after `latency` waits.
    always @(posedge clk) wait_cnt <= (mem_read_valid && !mem_read_ready) ? wait_cnt + 1 : 0;
    assign mem_read_ready = mem_read_valid && (wait_cnt >= latency);
    assign mem_read_data  = (ret_en && mem_read_address == ret_addr) ? 16'hF000
                                                                     : {8'h30, mem_read_address};
    assign ready_fe = valid_fe;
    assign data_fe  = {8'h30, addr_fe};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Samples pops and accepted requests at the negedge, then advances to posedge+1.
    task automatic tick();
        @(negedge clk);
        if (reset) begin
            if (fetch_valid && enable && !stall && !flush)
                got_q.push_back({fetch_pc, fetched_instruction});
            if (mem_read_valid && mem_read_ready) req_q.push_back(mem_read_address);
            if (valid_fe && ready_fe) req_fe_q.push_back(addr_fe);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [7:0] pc_v, input logic [15:0] instr_v);
        exp_q.push_back({pc_v, instr_v});
    endtask

    task automatic drain_compare(input string tag, input int budget);
        int     cycles;
        fetch_t g;
        fetch_t e;
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            if (got_q.size() != 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                check(tag, 32'(g), 32'(e));
            end else begin
                tick();
                cycles++;
            end
        end
        if (exp_q.size() != 0) begin
            check({tag, " timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        enable = 1'b0;
        stall  = 1'b0;
        flush  = 1'b0;
        ret_en = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        got_q.delete();
        exp_q.delete();
        req_q.delete();
        req_fe_q.delete();
    endtask

    initial begin
        // Reset state and first-fetch latency with zero-wait memory.
        do_reset();
        check("rst fetch_valid", fetch_valid, 0);
        check("rst mem_valid", mem_read_valid, 0);
        check("rst mem_addr", mem_read_address, 8'h00);
        check("rst halted", halted, 0);
        check("rst instr", fetched_instruction, 16'h0000);
        latency = 0;
        enable  = 1'b1;
        tick();
        check("t1 cyc1 fetch_valid", fetch_valid, 0);
        check("t1 cyc1 mem_valid", mem_read_valid, 1);
        check("t1 cyc1 mem_addr", mem_read_address, 8'h00);
        tick();
        check("t1 cyc2 fetch_valid", fetch_valid, 1);
        check("t1 head instr", fetched_instruction, 16'h3000);
        check("t1 head pc", fetch_pc, 8'h00);
        for (int i = 0; i < 3; i++) expect_fetch(8'(i), 16'h3000 + 16'(i));
        drain_compare("t1 stream", 20);

        // Stalled pipeline fills the FIFO without overflow; release drains in order.
        do_reset();
        latency = 1;
        stall   = 1'b1;
        enable  = 1'b1;
        repeat (20) tick();
        check("t2 full fetch_valid", fetch_valid, 1);
        check("t2 full head", fetched_instruction, 16'h3000);
        check("t2 full mem_valid", mem_read_valid, 0);
        check("t2 req count", 32'(req_q.size()), 32'd4);
        stall = 1'b0;
        for (int i = 0; i < 5; i++) expect_fetch(8'(i), 16'h3000 + 16'(i));
        drain_compare("t2 drain", 40);
        check("t2 resume addr", req_q[4], 8'h04);

        // Flush while address 0x05 is outstanding on a slow memory.
        do_reset();
        latency = 3;
        enable  = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (mem_read_valid && mem_read_address == 8'h05 && !mem_read_ready) break;
        end
        check("t3 reach addr5", mem_read_address, 8'h05);
        got_q.delete();
        req_q.delete();
        redirect_pc = 8'h40;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3 drain valid", mem_read_valid, 1);
        check("t3 drain addr", mem_read_address, 8'h05);
        check("t3 fifo cleared", fetch_valid, 0);
        tick();
        check("t3 drain addr hold", mem_read_address, 8'h05);
        expect_fetch(8'h40, 16'h3040);
        expect_fetch(8'h41, 16'h3041);
        drain_compare("t3 redirect", 40);
        check("t3 drained req", req_q[0], 8'h05);
        check("t3 next req", req_q[1], 8'h40);

        // RET at 0x07 halts fetching; a flush resumes at 0x10.
        do_reset();
        latency  = 0;
        ret_en   = 1'b1;
        ret_addr = 8'h07;
        enable   = 1'b1;
        for (int i = 0; i < 7; i++) expect_fetch(8'(i), 16'h3000 + 16'(i));
        expect_fetch(8'h07, 16'hF000);
        drain_compare("t4 to ret", 40);
        repeat (5) tick();
        check("t4 halted", halted, 1);
        check("t4 no request", mem_read_valid, 0);
        check("t4 req count", 32'(req_q.size()), 32'd8);
        got_q.delete();
        req_q.delete();
        redirect_pc = 8'h10;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4 unhalt", halted, 0);
        check("t4 resume addr", mem_read_address, 8'h10);
        expect_fetch(8'h10, 16'h3010);
        expect_fetch(8'h11, 16'h3011);
        drain_compare("t4 resume", 20);

        // RESET_PC=0xFE instance: PC wraps through 0xFF to 0x00.
        do_reset();
        stall  = 1'b1;
        enable = 1'b1;
        repeat (12) tick();
        check("t5 req0", req_fe_q[0], 8'hFE);
        check("t5 req1", req_fe_q[1], 8'hFF);
        check("t5 req2", req_fe_q[2], 8'h00);
        check("t5 head pc", fetch_pc_fe, 8'hFE);
        check("t5 head instr", instr_fe, 16'h30FE);
        check("t5 valid", fetch_valid_fe, 1);
        check("t5 halted", halted_fe, 0);

        // Reset mid-handshake with three buffered entries.
        do_reset();
        latency = 2;
        stall   = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (req_q.size() == 3 && mem_read_valid && !mem_read_ready) break;
        end
        check("t6 pre count", 32'(req_q.size()), 32'd3);
        check("t6 pre inflight", mem_read_valid, 1);
        reset = 1'b0;
        tick();
        check("t6 fetch_valid", fetch_valid, 0);
        check("t6 mem_valid", mem_read_valid, 0);
        check("t6 mem_addr", mem_read_address, 8'h00);
        check("t6 instr", fetched_instruction, 16'h0000);
        reset = 1'b1;
        tick();
        check("t6 restart valid", mem_read_valid, 1);
        check("t6 restart addr", mem_read_address, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the core's 5-stage pipeline.
- Generates the fetch PC and reads 16-bit instructions from program memory through a valid/ready handshake.
- Buffers fetched words in a small prefetch FIFO and presents them to the pipeline's fetch input (fetched_instruction/fetch_valid).
- Honours the pipeline's stall and flush/redirect signals, and halts after fetching RET.

Parameters:
ADDR_BITS, 8, program memory address width (PC width)
INSTR_BITS, 16, instruction width
FIFO_DEPTH, 4, prefetch buffer entries (power of two, >=2)
RESET_PC, 0, PC loaded on reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets)
enable  input  1  core enable; when low, no new requests and no pops
stall  input  1  pipeline_stall from pipeline; blocks pops
flush  input  1  discard buffered/in-flight instructions, redirect
redirect_pc  input  ADDR_BITS  new PC, sampled when flush==1
mem_read_valid  output  1  read request valid
mem_read_address  output  ADDR_BITS  read address
mem_read_ready  input  1  memory returns data this cycle
mem_read_data  input  INSTR_BITS  instruction word, valid when mem_read_ready
fetched_instruction  output  INSTR_BITS  FIFO head instruction
fetch_valid  output  1  FIFO non-empty
fetch_pc  output  ADDR_BITS  PC of FIFO head
halted  output  1  RET fetched, requesting stopped

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, pc=RESET_PC, FIFO empty (count=0), mem_read_valid=0, mem_read_address=RESET_PC, halted=0. Reset overrides all other inputs.
- fetched_instruction and fetch_pc are combinational from the FIFO head; they read 0 when empty. fetch_valid = (count!=0).
- Pop condition: fetch_valid && enable && !stall && !flush. A pop removes the head at the posedge.
- Memory handshake:
  - At most one request outstanding.
  - Once mem_read_valid is raised, mem_read_valid and mem_read_address stay stable until the cycle mem_read_ready==1.
  - mem_read_data is captured in that same cycle, and mem_read_valid drops the next cycle unless a new request issues back-to-back.
- Issue rule: a new request may start only if enable && (count + pops_pending_this_cycle_excluded) < FIFO_DEPTH. Credit counts the outstanding request, i.e. count+1 <= FIFO_DEPTH after acceptance. No request is issued when the FIFO would overflow.
- States and transitions:
  - IDLE: enable -> REQ.
  - REQ: mem_read_valid=1 at pc. On ready: push {pc, data}, pc<=pc+1. If data[15:12]==4'hF (RET) -> HALTED. Else stay in REQ if the issue rule holds, otherwise WAIT_SPACE.
  - WAIT_SPACE: mem_read_valid=0. When space is available and enable -> REQ.
  - HALTED: halted=1, no requests. flush -> REQ at redirect_pc.
  - DRAIN: entered on flush while a request is outstanding and not accepted the same cycle. Keeps valid/address stable until ready, discards the data (no push), then -> REQ at the latched redirect_pc.
- Flush (not in reset): FIFO cleared the same edge, halted<=0, pc<=redirect_pc. Next state is REQ, or DRAIN per the rule above. A flush arriving in the same cycle as ready also discards that data. Flush wins over push and pop.
- PC arithmetic: modulo 2^ADDR_BITS; 0xFF+1 -> 0x00 for ADDR_BITS=8.
- Simultaneous push and pop: count unchanged, order preserved. Pop from an empty FIFO: ignored.
- enable low: the current handshake completes (its data is pushed), no new request starts, no pops.
- Latency: first fetch_valid no earlier than 2 cycles after enable rises with zero-wait memory (request cycle, push edge).

Test Plan:
1. Reset then enable with a zero-wait memory returning data=addr|0x3000 -> fetch_valid by cycle 2. Head 0x3000, pc 0. With stall=0, one instruction per cycle, sequence 0x3000,0x3001,0x3002.
2. stall=1 held with 1-cycle-latency memory -> FIFO fills to 4 (0x3000..0x3003), mem_read_valid stays 0 with no overflow. Release stall -> drains in order and fetching resumes at address 4.
3. Memory with 3-cycle ready delay: flush with redirect_pc=0x40 while a request to 0x05 is outstanding -> address 0x05 held until ready, its data never appears on fetched_instruction, next request is to 0x40.
4. Word 0xF000 at address 0x07 -> pushed and delivered. halted=1, no further mem_read_valid. Flush with redirect_pc=0x10 -> halted=0 and fetch resumes at 0x10.
5. Start at RESET_PC=0xFE -> requests go to 0xFE, 0xFF, 0x00.
6. Pull reset low mid-handshake with FIFO holding 3 entries -> next cycle fetch_valid=0, mem_read_valid=0, state IDLE, pc=RESET_PC.
